prng_word_buffer: RTL and testbench
===================================

# prng_word_buffer

Downstream stage of the `prng` block in the ROLLO encrypt datapath. It issues seed and continuation requests to `prng`, captures each 96-bit `out_rng` block, and serialises it MSB-first into DIGIT-wide words on a valid/ready stream for the encryption core's random-vector samplers. A watchdog flags a PRNG response that never arrives.

## Interface
- DIGIT, 32, output word width; legal values 8, 16, 32, 48, 96 (must divide 96).
- WDOG, 63, maximum cycles to wait for `prng_out_ready` after a request.
- clk  in  1  clock.
- rst_b  in  1  synchronous, active-high reset (1 = reset).
- seed_valid  in  1  new seed available.
- seed  in  96  seed value.
- seed_ack  out  1  one-cycle pulse: seed accepted.
- run  in  1  keep generating blocks after the current one.
- prng_in_ready  out  1  request pulse to `prng.in_ready`.
- prng_in_seed  out  96  seed to `prng.in_seed`.
- prng_in_mod  out  1  1 = reseed, 0 = continue.
- prng_out_rng  in  96  from `prng.out_rng`.
- prng_out_ready  in  1  from `prng.out_ready`.
- rnd_valid  out  1  `rnd_data` valid.
- rnd_data  out  DIGIT  random word.
- rnd_ready  in  1  consumer accepts word.
- wdog_err  out  1  sticky error: PRNG timed out.

## Operation
- States: IDLE, REQ, WAIT, DRAIN, ERR.
- IDLE: if `seed_valid`, register `seed`, pulse `seed_ack`, set `reseed` = 1, go to REQ. `seed_valid` in any other state is ignored with no ack.
- REQ (one cycle): `prng_in_ready` = 1; `prng_in_mod` = `reseed`; `prng_in_seed` = the registered seed when `reseed` = 1, else 0. Clear `reseed`, clear the watchdog counter, go to WAIT.
- WAIT: increment the watchdog counter each cycle. On `prng_out_ready`, load the 96-bit buffer with `prng_out_rng`, set the word counter to 96/DIGIT, go to DRAIN. If the counter reaches WDOG first, set `wdog_err` and go to ERR.
- DRAIN: `rnd_valid` = 1 and `rnd_data` = `buf[95:96-DIGIT]`. On `rnd_valid & rnd_ready`, shift the buffer left by DIGIT and decrement the word counter. On the last handshake, go to REQ if `run` = 1, else IDLE.
- ERR: all outputs are held inactive except `wdog_err`. Only reset exits ERR.
- `prng_out_ready` outside WAIT is ignored (except the prefetch capture described under Configuration).
- Reset in any state: return to IDLE, discard buffer contents. Any in-flight PRNG result is lost; `prng` shares `rst_b`.

## Timing
- Reset values: `seed_ack` 0, `prng_in_ready` 0, `prng_in_seed` 0, `prng_in_mod` 0, `rnd_valid` 0, `rnd_data` 0, `wdog_err` 0.
- All outputs are registered.
- `seed_ack` is asserted the cycle after `seed_valid` is sampled in IDLE. `prng_in_ready` is asserted the cycle after that.
- `rnd_valid` rises the cycle after `prng_out_ready` is sampled in WAIT.
- Once `rnd_valid` is high, `rnd_data` holds stable until the handshake.
- With DIGIT = 96 there is one word per block. The word counter width is clog2(96/DIGIT + 1).
- Without prefetch: gap between blocks = 1 (REQ) + PRNG latency + 1 cycle.

## Configuration
- `PRNG_BUF_PREFETCH_EN` defined:
  - Adds a 96-bit hold register plus a `hold_full` flag.
  - The next request (`prng_in_mod` = 0) is issued the cycle after DRAIN is entered, when `run` = 1 and the hold register is empty. The watchdog runs in parallel.
  - `prng_out_ready` in DRAIN fills the hold register.
  - On the last handshake with `hold_full` = 1, the buffer loads from the hold register in the same cycle. `rnd_valid` stays high and there is no bubble.
  - If `run` drops, the held block is still drained, then the block goes to IDLE.
- Undefined: behaviour is exactly as in Operation.

## Structure
- Shared package `rollo_rng_pkg`: state enum encoding, the 96-bit block width constant `RNG_BLK_W`, and the words-per-block function.
- One sub-module, `rng_wdog`: watchdog counter with `clear`, `en`, and `expired` ports.

## Test plan
- Seed 0x0123…AB, `run` = 0, DIGIT = 32, `rnd_ready` = 1, prng model returning 0xDEADBEEF_CAFEF00D_12345678 after 19 cycles:
  - `seed_ack` one cycle after `seed_valid`.
  - `prng_in_mod` = 1 and `prng_in_seed` equals the seed.
  - Words DEADBEEF, CAFEF00D, 12345678 in order; return to IDLE.
- `rnd_ready` toggled 1,0,0,1: `rnd_data` stays CAFEF00D across the stall; exactly 3 handshakes.
- `run` = 1 held: second request has `prng_in_mod` = 0 and `prng_in_seed` = 0; six words over two blocks.
- PRNG model never responds, WDOG = 63: `wdog_err` = 1 exactly 63 cycles after REQ; `rnd_valid` stays 0; only reset clears it.
- `seed_valid` during DRAIN: no `seed_ack`, and the stream is unchanged.
- Reset asserted mid-DRAIN after 1 word, then a late `prng_out_ready`: outputs at reset values and nothing captured. With `PRNG_BUF_PREFETCH_EN` defined, two blocks stream with `rnd_valid` continuously high.

Source files
------------

// File: rtl/rollo_rng_pkg.sv
// rollo_rng_pkg: shared state encoding, block width and word-count helper
// for the ROLLO PRNG word buffer.
package rollo_rng_pkg;

  localparam int RNG_BLK_W = 96;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } rng_state_e;

  // Number of output words carried by one PRNG block.
  function automatic int words_per_blk(input int digit);
    return RNG_BLK_W / digit;
  endfunction

endpackage

// File: rtl/rng_wdog.sv
// rng_wdog: response watchdog. Counts enabled cycles since the last clear and
// flags the cycle on which the count reaches WDOG.
module rng_wdog #(
  parameter int WDOG = 63
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(WDOG + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear wins; otherwise count while enabled, saturating at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(WDOG))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // fires on the enabled cycle whose increment brings the count to WDOG
  assign expired = en && !clear && (cnt_q == CW'(WDOG - 1));

endmodule

// File: rtl/prng_word_buffer.sv
// prng_word_buffer: requests 96-bit blocks from prng and streams them MSB-first
// as DIGIT-wide words. Optional block prefetch: PRNG_BUF_PREFETCH_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a seed
// ST_REQ   | issue one request to prng (reseed or continue)
// ST_WAIT  | waiting for prng_out_ready, watchdog running
// ST_DRAIN | presenting buffered words on the rnd stream
// ST_ERR   | prng timed out; only reset leaves
module prng_word_buffer
  import rollo_rng_pkg::*;
#(
  parameter int DIGIT = 32,
  parameter int WDOG  = 63
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 seed_valid,
  input  logic [RNG_BLK_W-1:0] seed,
  output logic                 seed_ack,
  input  logic                 run,
  output logic                 prng_in_ready,
  output logic [RNG_BLK_W-1:0] prng_in_seed,
  output logic                 prng_in_mod,
  input  logic [RNG_BLK_W-1:0] prng_out_rng,
  input  logic                 prng_out_ready,
  output logic                 rnd_valid,
  output logic [DIGIT-1:0]     rnd_data,
  input  logic                 rnd_ready,
  output logic                 wdog_err
);

  localparam int NWORDS = words_per_blk(DIGIT);
  localparam int WCW    = $clog2(NWORDS + 1);

  rng_state_e           state_q, state_d;
  logic [RNG_BLK_W-1:0] seed_q, seed_d;
  logic                 reseed_q, reseed_d;
  logic [RNG_BLK_W-1:0] buf_q, buf_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic                 seed_ack_q, seed_ack_d;
  logic                 in_ready_q, in_ready_d;
  logic                 in_mod_q, in_mod_d;
  logic [RNG_BLK_W-1:0] in_seed_q, in_seed_d;
  logic                 rnd_valid_q, rnd_valid_d;
  logic                 wdog_err_q, wdog_err_d;
`ifdef PRNG_BUF_PREFETCH_EN
  logic [RNG_BLK_W-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 req_out_q, req_out_d;
`endif

  logic wdog_clear;
  logic wdog_en;
  logic wdog_expired;
  logic hs;
  logic last_hs;

  assign hs      = rnd_valid_q & rnd_ready;
  assign last_hs = hs && (wcnt_q == WCW'(1));

  rng_wdog #(.WDOG(WDOG)) u_wdog (
    .clk     (clk),
    .rst_b   (rst_b),
    .clear   (wdog_clear),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    reseed_d    = reseed_q;
    buf_d       = buf_q;
    wcnt_d      = wcnt_q;
    seed_ack_d  = 1'b0;
    in_ready_d  = 1'b0;
    in_mod_d    = 1'b0;
    in_seed_d   = '0;
    rnd_valid_d = rnd_valid_q;
    wdog_err_d  = wdog_err_q;
    wdog_clear  = 1'b0;
    wdog_en     = 1'b0;
`ifdef PRNG_BUF_PREFETCH_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    req_out_d   = req_out_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (seed_valid) begin
          seed_d     = seed;
          seed_ack_d = 1'b1;
          reseed_d   = 1'b1;
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        in_ready_d = 1'b1;
        in_mod_d   = reseed_q;
        in_seed_d  = reseed_q ? seed_q : '0;
        reseed_d   = 1'b0;
        wdog_clear = 1'b1;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        wdog_en = 1'b1;
        if (prng_out_ready) begin
          buf_d       = prng_out_rng;
          wcnt_d      = WCW'(NWORDS);
          rnd_valid_d = 1'b1;
          state_d     = ST_DRAIN;
        end else if (wdog_expired) begin
          wdog_err_d = 1'b1;
          state_d    = ST_ERR;
        end
      end

      ST_DRAIN: begin
`ifdef PRNG_BUF_PREFETCH_EN
        wdog_en = req_out_q;
        if (req_out_q && prng_out_ready) begin
          hold_d      = prng_out_rng;
          hold_full_d = 1'b1;
          req_out_d   = 1'b0;
        end
        // the final handshake of a block without a prefetch falls back to ST_REQ,
        // so no extra request is issued on that edge
        if (run && !hold_full_q && !req_out_q && !last_hs) begin
          in_ready_d = 1'b1;
          wdog_clear = 1'b1;
          req_out_d  = 1'b1;
        end
`endif
        if (hs) begin
          buf_d  = buf_q << DIGIT;
          wcnt_d = wcnt_q - WCW'(1);
          if (last_hs) begin
`ifdef PRNG_BUF_PREFETCH_EN
            if (hold_full_q) begin
              buf_d       = hold_q;
              hold_full_d = 1'b0;
              wcnt_d      = WCW'(NWORDS);
            end else if (req_out_q && prng_out_ready) begin
              buf_d       = prng_out_rng;
              hold_full_d = 1'b0;
              wcnt_d      = WCW'(NWORDS);
            end else if (req_out_q) begin
              // response still in flight: keep the watchdog running in ST_WAIT
              rnd_valid_d = 1'b0;
              req_out_d   = 1'b0;
              state_d     = ST_WAIT;
            end else begin
              rnd_valid_d = 1'b0;
              state_d     = run ? ST_REQ : ST_IDLE;
            end
`else
            rnd_valid_d = 1'b0;
            state_d     = run ? ST_REQ : ST_IDLE;
`endif
          end
        end
`ifdef PRNG_BUF_PREFETCH_EN
        if (req_out_q && !prng_out_ready && wdog_expired) begin
          buf_d       = '0;
          wcnt_d      = '0;
          rnd_valid_d = 1'b0;
          req_out_d   = 1'b0;
          hold_full_d = 1'b0;
          wdog_err_d  = 1'b1;
          state_d     = ST_ERR;
        end
`endif
      end

      ST_ERR: begin
        rnd_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      reseed_q    <= 1'b0;
      buf_q       <= '0;
      wcnt_q      <= '0;
      seed_ack_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      in_mod_q    <= 1'b0;
      in_seed_q   <= '0;
      rnd_valid_q <= 1'b0;
      wdog_err_q  <= 1'b0;
`ifdef PRNG_BUF_PREFETCH_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      req_out_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      reseed_q    <= reseed_d;
      buf_q       <= buf_d;
      wcnt_q      <= wcnt_d;
      seed_ack_q  <= seed_ack_d;
      in_ready_q  <= in_ready_d;
      in_mod_q    <= in_mod_d;
      in_seed_q   <= in_seed_d;
      rnd_valid_q <= rnd_valid_d;
      wdog_err_q  <= wdog_err_d;
`ifdef PRNG_BUF_PREFETCH_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      req_out_q   <= req_out_d;
`endif
    end
  end

  // the buffer is all-zero whenever no block is held, so rnd_data idles at 0
  assign seed_ack      = seed_ack_q;
  assign prng_in_ready = in_ready_q;
  assign prng_in_mod   = in_mod_q;
  assign prng_in_seed  = in_seed_q;
  assign rnd_valid     = rnd_valid_q;
  assign rnd_data      = buf_q[RNG_BLK_W-1 -: DIGIT];
  assign wdog_err      = wdog_err_q;

endmodule

// File: tb/tb_prng_word_buffer.sv
// tb_prng_word_buffer: randomized scoreboard bench with a behavioural prng model.
module tb_prng_word_buffer;

  localparam int DIGIT = 32;
  localparam int WDOG  = 63;
  localparam int NW    = 96 / DIGIT;
  localparam logic [95:0] SEED0 = 96'h0123_4567_89AB_CDEF_0123_45AB;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              seed_valid;
  logic [95:0]       seed;
  logic              seed_ack;
  logic              run;
  logic              prng_in_ready;
  logic [95:0]       prng_in_seed;
  logic              prng_in_mod;
  logic [95:0]       prng_out_rng;
  logic              prng_out_ready;
  logic              rnd_valid;
  logic [DIGIT-1:0]  rnd_data;
  logic              rnd_ready;
  logic              wdog_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model controls (written by main only)
  int          lat_fixed = 19;
  bit          lat_rand  = 1'b0;
  bit          blk_rand  = 1'b0;
  logic [95:0] blk_fixed = 96'hDEADBEEF_CAFEF00D_12345678;
  bit          no_resp   = 1'b0;
  int          seeds_acc = 0;
  logic [95:0] exp_seed  = '0;
  int          inject_req = 0;

  // model status (written by model only)
  int n_req = 0;
  int n_resp = 0;
  int resp_cyc = 0;
  bit model_busy = 1'b0;
  int inject_done = 0;

  // scoreboard and monitor status
  logic [DIGIT-1:0] exp_q[$];
  int hs_cnt = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prng_word_buffer #(.DIGIT(DIGIT), .WDOG(WDOG)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .seed_valid     (seed_valid),
    .seed           (seed),
    .seed_ack       (seed_ack),
    .run            (run),
    .prng_in_ready  (prng_in_ready),
    .prng_in_seed   (prng_in_seed),
    .prng_in_mod    (prng_in_mod),
    .prng_out_rng   (prng_out_rng),
    .prng_out_ready (prng_out_ready),
    .rnd_valid      (rnd_valid),
    .rnd_data       (rnd_data),
    .rnd_ready      (rnd_ready),
    .wdog_err       (wdog_err)
  );

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // prng model: first request after each accepted seed is a reseed with that
  // seed, later ones continue with a zero seed; answers after a latency
  initial begin : prng_model
    int          seen_seeds;
    int          lat;
    logic [95:0] blk;
    bit          exp_mod;
    logic [95:0] exp_s;
    seen_seeds     = 0;
    prng_out_rng   = '0;
    prng_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b) continue;
      if (inject_req != inject_done) begin
        @(posedge clk);
        #1;
        prng_out_rng   = {$urandom(), $urandom(), $urandom()};
        prng_out_ready = 1'b1;
        @(posedge clk);
        #1;
        prng_out_ready = 1'b0;
        inject_done++;
      end else if (prng_in_ready) begin
        model_busy = 1'b1;
        exp_mod    = (seen_seeds != seeds_acc);
        exp_s      = exp_mod ? exp_seed : '0;
        seen_seeds = seeds_acc;
        chk("req_mod", 96'(prng_in_mod), 96'(exp_mod));
        chk("req_seed", prng_in_seed, exp_s);
        n_req++;
        if (!no_resp) begin
          lat = lat_rand ? int'($urandom_range(1, 25)) : lat_fixed;
          blk = blk_rand ? {$urandom(), $urandom(), $urandom()} : blk_fixed;
          repeat (lat) @(posedge clk);
          #1;
          prng_out_rng   = blk;
          prng_out_ready = 1'b1;
          resp_cyc       = cyc;
          n_resp++;
          for (int i = 0; i < NW; i++) exp_q.push_back(DIGIT'(blk >> (96 - DIGIT * (i + 1))));
          @(posedge clk);
          #1;
          prng_out_ready = 1'b0;
        end
        model_busy = 1'b0;
      end
    end
  end

  // monitor: pops expected words on each handshake, checks stall stability
  initial begin : monitor
    bit               stall;
    logic [DIGIT-1:0] stall_d;
    logic [DIGIT-1:0] w;
    stall   = 1'b0;
    stall_d = '0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        stall = 1'b0;
        exp_q.delete();
        continue;
      end
      if (seed_ack) ack_cnt++;
      if (rnd_valid && stall) begin
        checks++;
        if (rnd_data !== stall_d) begin
          errors++;
          $display("FAIL stall_stable got %h want %h", rnd_data, stall_d);
        end
      end
      if (rnd_valid && rnd_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected got %h want none", rnd_data);
        end else begin
          w = exp_q.pop_front();
          if (rnd_data !== w) begin
            errors++;
            $display("FAIL word got %h want %h", rnd_data, w);
          end
        end
        stall = 1'b0;
      end else if (rnd_valid) begin
        stall   = 1'b1;
        stall_d = rnd_data;
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_b      = 1'b1;
    seed_valid = 1'b0;
    rnd_ready  = 1'b1;
    run        = 1'b0;
    repeat (3) tick();
    rst_b = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seed_ack"}, 96'(seed_ack), 96'(0));
    chk({tag, "_in_ready"}, 96'(prng_in_ready), 96'(0));
    chk({tag, "_in_seed"}, prng_in_seed, 96'(0));
    chk({tag, "_in_mod"}, 96'(prng_in_mod), 96'(0));
    chk({tag, "_rnd_valid"}, 96'(rnd_valid), 96'(0));
    chk({tag, "_rnd_data"}, 96'(rnd_data), 96'(0));
    chk({tag, "_wdog_err"}, 96'(wdog_err), 96'(0));
  endtask

  // called one step after a clock edge with the DUT idle
  task automatic send_seed(input logic [95:0] s);
    seed       = s;
    seed_valid = 1'b1;
    exp_seed   = s;
    seeds_acc++;
    tick();
    seed_valid = 1'b0;
    chk("seed_ack", 96'(seed_ack), 96'(1));
    tick();
    chk("seed_ack_pulse", 96'(seed_ack), 96'(0));
    chk("req_after_ack", 96'(prng_in_ready), 96'(1));
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!rnd_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!rnd_valid) begin
      errors++;
      $display("FAIL %s timeout got valid=0 want 1 within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rnd_valid || model_busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout got pending=%0d want 0", name, exp_q.size());
    end
    repeat (3) tick();
  endtask

  initial begin : main
    int  h0, r0, a0, p0, t0, n;
    bit  bad;
    seed = '0;
    do_reset();
    chk_reset_outputs("rst");

    // fixed block, latency 19, run=0
    h0 = hs_cnt; r0 = n_req;
    send_seed(SEED0);
    chk("first_mod", 96'(prng_in_mod), 96'(1));
    chk("first_seed", prng_in_seed, SEED0);
    wait_valid("t1_valid", 100);
    chk("valid_latency", 96'(cyc), 96'(resp_cyc + 1));
    wait_idle("t1_idle", 200);
    chk("t1_words", 96'(hs_cnt - h0), 96'(NW));
    chk("t1_reqs", 96'(n_req - r0), 96'(1));

    // consumer stall pattern 1,0,0,1
    lat_fixed = 4;
    h0 = hs_cnt;
    send_seed({$urandom(), $urandom(), $urandom()});
    wait_valid("t2_valid", 100);
    tick();
    rnd_ready = 1'b0;
    chk("stall_word_a", 96'(rnd_data), 96'(32'hCAFEF00D));
    tick();
    chk("stall_word_b", 96'(rnd_data), 96'(32'hCAFEF00D));
    tick();
    rnd_ready = 1'b1;
    chk("stall_word_c", 96'(rnd_data), 96'(32'hCAFEF00D));
    wait_idle("t2_idle", 100);
    chk("t2_words", 96'(hs_cnt - h0), 96'(NW));

    // seed_valid during DRAIN is ignored
    blk_rand = 1'b1;
    h0 = hs_cnt; r0 = n_req;
    send_seed({$urandom(), $urandom(), $urandom()});
    wait_valid("t3_valid", 100);
    a0 = ack_cnt;
    rnd_ready  = 1'b0;
    seed       = {$urandom(), $urandom(), $urandom()};
    seed_valid = 1'b1;
    tick();
    tick();
    seed_valid = 1'b0;
    rnd_ready  = 1'b1;
    wait_idle("t3_idle", 100);
    chk("drain_seed_no_ack", 96'(ack_cnt - a0), 96'(0));
    chk("drain_seed_no_req", 96'(n_req - r0), 96'(1));
    chk("t3_words", 96'(hs_cnt - h0), 96'(NW));

    // run=1 over random latency, data and back-pressure
    lat_rand = 1'b1;
    h0 = hs_cnt; r0 = n_req; p0 = n_resp;
    run = 1'b1;
    send_seed({$urandom(), $urandom(), $urandom()});
    n = 0;
    while ((hs_cnt - h0) < NW + 1 && n < 3000) begin
      rnd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    run = 1'b0;
    while (n < 3000 && (exp_q.size() != 0 || rnd_valid || model_busy)) begin
      rnd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rnd_ready = 1'b1;
    wait_idle("t4_idle", 300);
    chk("run_two_blocks", 96'((n_req - r0) >= 2), 96'(1));
    chk("run_words", 96'(hs_cnt - h0), 96'(NW * (n_resp - p0)));

`ifdef PRNG_BUF_PREFETCH_EN
    // prefetch: two blocks with rnd_valid continuously high
    lat_rand = 1'b0;
    lat_fixed = 1;
    run = 1'b1;
    send_seed({$urandom(), $urandom(), $urandom()});
    wait_valid("t5_valid", 100);
    bad = 1'b0;
    for (int i = 0; i < 2 * NW; i++) begin
      if (!rnd_valid) bad = 1'b1;
      tick();
    end
    run = 1'b0;
    chk("prefetch_no_bubble", 96'(bad), 96'(0));
    wait_idle("t5_idle", 300);
`endif

    // watchdog: prng never answers
    lat_rand = 1'b0;
    lat_fixed = 8;
    no_resp = 1'b1;
    send_seed({$urandom(), $urandom(), $urandom()});
    t0 = cyc;
    bad = 1'b0;
    n = 0;
    while (!wdog_err && n < 200) begin
      if (rnd_valid) bad = 1'b1;
      tick();
      n++;
    end
    chk("wdog_delay", 96'(cyc - t0), 96'(WDOG));
    chk("wdog_no_valid", 96'(bad), 96'(0));
    a0 = ack_cnt;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    repeat (20) tick();
    chk("err_sticky", 96'(wdog_err), 96'(1));
    chk("err_no_ack", 96'(ack_cnt - a0), 96'(0));
    chk("err_valid_low", 96'(rnd_valid), 96'(0));
    no_resp = 1'b0;
    do_reset();
    chk("err_cleared", 96'(wdog_err), 96'(0));

    // reset mid-DRAIN after one word, then a late prng_out_ready
    r0 = n_req;
    send_seed({$urandom(), $urandom(), $urandom()});
    wait_valid("t6_valid", 100);
    tick();
    rst_b     = 1'b1;
    rnd_ready = 1'b0;
    tick();
    tick();
    rst_b = 1'b0;
    h0 = hs_cnt;
    rnd_ready = 1'b1;
    inject_req++;
    bad = 1'b0;
    n = 0;
    while ((inject_done != inject_req || n < 6) && n < 100) begin
      tick();
      if (rnd_valid) bad = 1'b1;
      n++;
    end
    chk("late_rng_ignored", 96'(bad), 96'(0));
    chk("late_no_words", 96'(hs_cnt - h0), 96'(0));
    chk("late_no_req", 96'(n_req - r0), 96'(1));
    chk_reset_outputs("late");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench timeout");
  end

endmodule
